// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide sharing one
// radix-2 datapath; results land in HI/LO, with a divide-by-zero pulse.
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   start, op, a, b   - request, operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//                       and operands, sampled while idle
//   busy              - operation in flight (CALC and FIX)
//   done, div0        - one-cycle completion and divide-by-zero pulses
//   hi, lo            - product halves, or remainder/quotient
//   counter           - current iteration index (debug)
module muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic               div0,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic [CNT_W-1:0]   counter
);

   localparam int unsigned W2 = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state, state_nxt;
   logic               is_div_r, is_div_nxt;
   logic               sign_a_r, sign_a_nxt;
   logic               sign_b_r, sign_b_nxt;
   logic               dz_r, dz_nxt;
   logic [WIDTH-1:0]   mag_r, mag_nxt;     // addend (mult) or divisor (div) magnitude
   logic [WIDTH-1:0]   rem_r, rem_nxt;     // upper product half / partial remainder
   logic [WIDTH-1:0]   acc_r, acc_nxt;     // multiplier bits / dividend -> quotient
   logic               busy_nxt, done_nxt, div0_nxt;
   logic [WIDTH-1:0]   hi_nxt, lo_nxt;
   logic [CNT_W-1:0]   cnt_nxt;

   // Operand magnitudes; only signed ops treat the top bit as a sign
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   assign a_neg = ~op[0] & a[WIDTH-1];
   assign b_neg = ~op[0] & b[WIDTH-1];
   assign mag_a = a_neg ? WIDTH'(-a) : a;
   assign mag_b = b_neg ? WIDTH'(-b) : b;

   // One radix-2 step for each operation
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_try;
   logic               div_ok;
   assign mul_sum = {1'b0, rem_r} + (acc_r[0] ? {1'b0, mag_r} : {(WIDTH+1){1'b0}});
   assign div_try = {rem_r, acc_r[WIDTH-1]};
   assign div_ok  = div_try >= {1'b0, mag_r};

   // Sign-corrected results
   logic [W2-1:0]      prod_mag, prod_fix;
   logic               neg_res;
   assign prod_mag = {rem_r, acc_r};
   assign neg_res  = sign_a_r ^ sign_b_r;
   assign prod_fix = neg_res ? W2'(-prod_mag) : prod_mag;

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         is_div_r <= 1'b0;
         sign_a_r <= 1'b0;
         sign_b_r <= 1'b0;
         dz_r     <= 1'b0;
         mag_r    <= '0;
         rem_r    <= '0;
         acc_r    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div0     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         counter  <= '0;
      end else begin
         state    <= state_nxt;
         is_div_r <= is_div_nxt;
         sign_a_r <= sign_a_nxt;
         sign_b_r <= sign_b_nxt;
         dz_r     <= dz_nxt;
         mag_r    <= mag_nxt;
         rem_r    <= rem_nxt;
         acc_r    <= acc_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         div0     <= div0_nxt;
         hi       <= hi_nxt;
         lo       <= lo_nxt;
         counter  <= cnt_nxt;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_nxt  = state;
      is_div_nxt = is_div_r;
      sign_a_nxt = sign_a_r;
      sign_b_nxt = sign_b_r;
      dz_nxt     = dz_r;
      mag_nxt    = mag_r;
      rem_nxt    = rem_r;
      acc_nxt    = acc_r;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      div0_nxt   = 1'b0;
      hi_nxt     = hi;
      lo_nxt     = lo;
      cnt_nxt    = counter;

      case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            if (start) begin
               is_div_nxt = op[1];
               sign_a_nxt = a_neg;
               sign_b_nxt = b_neg;
               rem_nxt    = '0;
               cnt_nxt    = '0;
               busy_nxt   = 1'b1;
               if (op[1]) begin
                  mag_nxt = mag_b;
                  acc_nxt = mag_a;
               end else begin
                  mag_nxt = mag_a;
                  acc_nxt = mag_b;
               end
               if (op[1] && (b == '0)) begin
                  dz_nxt    = 1'b1;
                  state_nxt = FIX;
               end else begin
                  dz_nxt    = 1'b0;
                  state_nxt = CALC;
               end
            end
         end

         CALC: begin
            if (is_div_r) begin
               rem_nxt = div_ok ? WIDTH'(div_try - {1'b0, mag_r}) : div_try[WIDTH-1:0];
               acc_nxt = {acc_r[WIDTH-2:0], div_ok};
            end else begin
               rem_nxt = mul_sum[WIDTH:1];
               acc_nxt = {mul_sum[0], acc_r[WIDTH-1:1]};
            end
            cnt_nxt = CNT_W'(counter + 1'b1);
            if (counter == CNT_W'(WIDTH - 1)) begin
               state_nxt = FIX;
            end
         end

         FIX: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            div0_nxt  = dz_r;
            if (!dz_r) begin
               if (is_div_r) begin
                  // quotient follows the operand signs, remainder the dividend
                  lo_nxt = neg_res  ? WIDTH'(-acc_r) : acc_r;
                  hi_nxt = sign_a_r ? WIDTH'(-rem_r) : rem_r;
               end else begin
                  hi_nxt = prod_fix[W2-1:WIDTH];
                  lo_nxt = prod_fix[WIDTH-1:0];
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule
